// File: rtl/stream_check_pkg.sv
// Shared types and defaults for stream_match_checker.
//   chk_state_e     : run-control states (IDLE, RUN, DONE)
//   CNT_W_DEF       : default counter / timestamp width
//   NUM_SAMPLES_DEF : default samples per run
package stream_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  localparam int CNT_W_DEF       = 32;
  localparam int NUM_SAMPLES_DEF = 100;

endpackage

// File: rtl/stream_match_checker_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
// Ports:
//   clk     : clock
//   aresetn : asynchronous active-low reset (count -> 0)
//   clr     : synchronous clear, wins over inc
//   inc     : count up by one unless already saturated
//   cnt     : current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/stream_match_checker.sv
// stream_match_checker: compares a DUT vector against a reference under a
// per-bit care mask for a fixed number of accepted samples, then reports
// pass/fail. Counts samples and mismatches and timestamps the first mismatch.
//
// Optional build macro STREAM_MATCH_CAPTURE_EN adds first_err_ref and
// first_err_dut, which hold the vector pair of the first mismatch.
//
// Ports:
//   clk, aresetn            : clock, asynchronous active-low reset
//   start                   : begin a run (honoured in IDLE/DONE only)
//   sample_valid            : ref_vec/dut_vec/care_mask valid this cycle
//   ref_vec, dut_vec        : expected / observed vectors
//   care_mask               : 1 = bit compared, 0 = don't care
//   busy, done, pass        : run status
//   mismatch                : one-cycle flag after a mismatching sample
//   sample_cnt, error_cnt   : accepted / mismatching samples this run
//   first_err_valid/_time   : first mismatch recorded, and its run cycle
//
// State table:
//   IDLE | after reset, waiting for start
//   RUN  | accepting samples
//   DONE | NUM_SAMPLES accepted, result held until start
module stream_match_checker
  import stream_check_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int NUM_SAMPLES = NUM_SAMPLES_DEF
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] ref_vec,
  input  logic [WIDTH-1:0] dut_vec,
  input  logic [WIDTH-1:0] care_mask,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] error_cnt,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_time
`ifdef STREAM_MATCH_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] first_err_ref,
  output logic [WIDTH-1:0] first_err_dut
`endif
);

  // Sample index that completes the run (sample_cnt before the final increment).
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  chk_state_e       state, state_nxt;
  logic             start_acc;
  logic             accept;
  logic             miss;
  logic             last;
  logic             pass_q;
  logic [CNT_W-1:0] cyc_cnt;

  assign miss = |((ref_vec ^ dut_vec) & care_mask);
  assign last = accept && (sample_cnt == LAST_IDX);
  assign pass = pass_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (sample_valid) begin
          accept = 1'b1;
          if (sample_cnt == LAST_IDX) state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          start_acc = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .aresetn (aresetn),
    .clr     (start_acc),
    .inc     (accept && miss),
    .cnt     (error_cnt)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sample_cnt      <= '0;
      cyc_cnt         <= '0;
      mismatch        <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_time  <= '0;
      pass_q          <= 1'b0;
    end else if (start_acc) begin
      sample_cnt      <= '0;
      cyc_cnt         <= '0;
      mismatch        <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_time  <= '0;
      pass_q          <= 1'b0;
    end else begin
      mismatch <= accept && miss;
      // Free-running run-cycle index; wraps by design.
      if (state == RUN) cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (accept) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        if (miss && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_time  <= cyc_cnt;
        end
      end
      // error_cnt has not yet absorbed the final sample, so fold it in here.
      if (last) pass_q <= (error_cnt == '0) && !miss;
    end
  end

`ifdef STREAM_MATCH_CAPTURE_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      first_err_ref <= '0;
      first_err_dut <= '0;
    end else if (start_acc) begin
      first_err_ref <= '0;
      first_err_dut <= '0;
    end else if (accept && miss && !first_err_valid) begin
      first_err_ref <= ref_vec;
      first_err_dut <= dut_vec;
    end
  end
`else
  // No capture registers in this build.
`endif

endmodule

// File: tb/tb_stream_match_checker.sv
module tb_stream_match_checker;

  logic       clk = 1'b0;
  logic       aresetn = 1'b1;
  logic       start = 1'b0;
  logic       sample_valid = 1'b0;
  logic [3:0] ref_vec = '0;
  logic [3:0] dut_vec = '0;
  logic [3:0] care_mask = '0;

  // DUT a: WIDTH=4, CNT_W=8, NUM_SAMPLES=4.  DUT b: WIDTH=4, CNT_W=2, NUM_SAMPLES=3.
  logic       busy_a, done_a, pass_a, mismatch_a, fev_a;
  logic [7:0] scnt_a, ecnt_a, fet_a;
  logic       busy_b, done_b, pass_b, mismatch_b, fev_b;
  logic [1:0] scnt_b, ecnt_b, fet_b;
`ifdef STREAM_MATCH_CAPTURE_EN
  logic [3:0] fref_a, fdut_a, fref_b, fdut_b;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_match_checker #(.WIDTH(4), .CNT_W(8), .NUM_SAMPLES(4)) dut_a (
    .clk(clk), .aresetn(aresetn), .start(start), .sample_valid(sample_valid),
    .ref_vec(ref_vec), .dut_vec(dut_vec), .care_mask(care_mask),
    .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch(mismatch_a),
    .sample_cnt(scnt_a), .error_cnt(ecnt_a),
    .first_err_valid(fev_a), .first_err_time(fet_a)
`ifdef STREAM_MATCH_CAPTURE_EN
    , .first_err_ref(fref_a), .first_err_dut(fdut_a)
`endif
  );

  stream_match_checker #(.WIDTH(4), .CNT_W(2), .NUM_SAMPLES(3)) dut_b (
    .clk(clk), .aresetn(aresetn), .start(start), .sample_valid(sample_valid),
    .ref_vec(ref_vec), .dut_vec(dut_vec), .care_mask(care_mask),
    .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch(mismatch_b),
    .sample_cnt(scnt_b), .error_cnt(ecnt_b),
    .first_err_valid(fev_b), .first_err_time(fet_b)
`ifdef STREAM_MATCH_CAPTURE_EN
    , .first_err_ref(fref_b), .first_err_dut(fdut_b)
`endif
  );

  // Reference model: run mode 0=idle, 1=running, 2=finished.
  typedef struct {
    int mode;
    int scnt;
    int ecnt;
    int cyc;
    bit fev;
    int fet;
    bit mm;
    bit pass;
    int fref;
    int fdut;
  } mdl_t;

  mdl_t ma, mb, ea, eb;
  mdl_t qa[$];
  mdl_t qb[$];

  function automatic mdl_t mdl_reset();
    mdl_t x;
    x.mode = 0; x.scnt = 0; x.ecnt = 0; x.cyc = 0; x.fev = 0;
    x.fet = 0; x.mm = 0; x.pass = 0; x.fref = 0; x.fdut = 0;
    return x;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int n, int cw, bit st, bit v,
                                    int r, int d, int k);
    mdl_t x = m;
    int lim = 1 << cw;
    bit miss;
    if (st && m.mode != 1) begin
      x = mdl_reset();
      x.mode = 1;
      return x;
    end
    x.mm = 0;
    if (m.mode == 1) begin
      if (v) begin
        miss = ((r ^ d) & k) != 0;
        x.scnt = m.scnt + 1;
        x.mm = miss;
        if (miss) begin
          if (m.ecnt < lim - 1) x.ecnt = m.ecnt + 1;
          if (!m.fev) begin
            x.fev = 1; x.fet = m.cyc; x.fref = r; x.fdut = d;
          end
        end
        if (x.scnt == n) begin
          x.mode = 2;
          x.pass = (x.ecnt == 0);
        end
      end
      x.cyc = (m.cyc + 1) % lim;
    end
    return x;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(string tag, mdl_t e, logic b, logic dn, logic p, logic mm,
                     logic [31:0] sc, logic [31:0] ec, logic fv, logic [31:0] ft);
    check({tag, ".busy"},            32'(b),  32'(e.mode == 1));
    check({tag, ".done"},            32'(dn), 32'(e.mode == 2));
    check({tag, ".pass"},            32'(p),  32'(e.pass));
    check({tag, ".mismatch"},        32'(mm), 32'(e.mm));
    check({tag, ".sample_cnt"},      sc,      e.scnt);
    check({tag, ".error_cnt"},       ec,      e.ecnt);
    check({tag, ".first_err_valid"}, 32'(fv), 32'(e.fev));
    check({tag, ".first_err_time"},  ft,      e.fet);
  endtask

  // Scoreboard monitor: pops one expectation per consumed edge.
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      cmp("a", ea, busy_a, done_a, pass_a, mismatch_a, 32'(scnt_a), 32'(ecnt_a),
          fev_a, 32'(fet_a));
`ifdef STREAM_MATCH_CAPTURE_EN
      check("a.first_err_ref", 32'(fref_a), ea.fref);
      check("a.first_err_dut", 32'(fdut_a), ea.fdut);
`endif
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      cmp("b", eb, busy_b, done_b, pass_b, mismatch_b, 32'(scnt_b), 32'(ecnt_b),
          fev_b, 32'(fet_b));
`ifdef STREAM_MATCH_CAPTURE_EN
      check("b.first_err_ref", 32'(fref_b), eb.fref);
      check("b.first_err_dut", 32'(fdut_b), eb.fdut);
`endif
    end
  end

  task automatic step(bit st, bit v, logic [3:0] r, logic [3:0] d, logic [3:0] k);
    start = st; sample_valid = v; ref_vec = r; dut_vec = d; care_mask = k;
    ma = mdl_step(ma, 4, 8, st, v, int'(r), int'(d), int'(k));
    mb = mdl_step(mb, 3, 2, st, v, int'(r), int'(d), int'(k));
    qa.push_back(ma);
    qb.push_back(mb);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic chk_zero(string tag);
    mdl_t z = mdl_reset();
    cmp({tag, ".a"}, z, busy_a, done_a, pass_a, mismatch_a, 32'(scnt_a), 32'(ecnt_a),
        fev_a, 32'(fet_a));
    cmp({tag, ".b"}, z, busy_b, done_b, pass_b, mismatch_b, 32'(scnt_b), 32'(ecnt_b),
        fev_b, 32'(fet_b));
  endtask

  initial begin
    logic [3:0] r, d, k;
    ma = mdl_reset();
    mb = mdl_reset();
    #2 aresetn = 1'b0;
    #1 chk_zero("rst");
    repeat (2) @(posedge clk);
    #2 aresetn = 1'b1;

    // Samples while idle are ignored.
    step(0, 1, 4'h3, 4'hC, 4'hF);
    step(0, 1, 4'h3, 4'hC, 4'hF);

    // All matching; the sample presented with start is ignored.
    step(1, 1, 4'hA, 4'h0, 4'hF);
    repeat (4) step(0, 1, 4'hA, 4'hA, 4'hF);
    idle(2);

    // First-error timestamp at run cycle 2, second error at cycle 3.
    step(1, 0, 4'h0, 4'h0, 4'h0);
    step(0, 1, 4'h5, 4'h5, 4'hF);
    step(0, 1, 4'h5, 4'h5, 4'hF);
    step(0, 1, 4'h5, 4'h4, 4'hF);
    step(0, 1, 4'h5, 4'h7, 4'hF);
    idle(2);

    // Care mask.
    step(1, 0, 4'h0, 4'h0, 4'h0);
    step(0, 1, 4'hF, 4'h0, 4'h0);
    step(0, 1, 4'hF, 4'h0, 4'h1);
    step(0, 1, 4'hF, 4'hF, 4'hF);
    step(0, 1, 4'h1, 4'h1, 4'hF);
    idle(2);

    // Gaps and start pulses mid-run.
    step(1, 0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 9; i++)
      step(i == 2 || i == 3, i % 2 == 0, 4'h6, (i == 4) ? 4'h2 : 4'h6, 4'hF);
    idle(2);

    // Reset mid-run after two samples.
    step(1, 0, 4'h0, 4'h0, 4'h0);
    step(0, 1, 4'h8, 4'h9, 4'hF);
    step(0, 1, 4'h8, 4'h8, 4'hF);
    aresetn = 1'b0;
    #1 chk_zero("midrst");
    ma = mdl_reset();
    mb = mdl_reset();
    @(posedge clk);
    #2 aresetn = 1'b1;
    idle(1);

    // Complete a run, then restart from DONE.
    step(1, 0, 4'h0, 4'h0, 4'h0);
    step(0, 1, 4'h2, 4'h3, 4'hF);
    repeat (3) step(0, 1, 4'h2, 4'h2, 4'hF);
    idle(1);
    step(1, 1, 4'h2, 4'h0, 4'hF);
    idle(2);

    // Saturation: every sample mismatches.
    step(1, 0, 4'h0, 4'h0, 4'h0);
    step(0, 1, 4'h9, 4'h6, 4'hF);
    step(0, 1, 4'h1, 4'h0, 4'hF);
    step(0, 1, 4'hC, 4'h4, 4'hF);
    step(0, 1, 4'h7, 4'h3, 4'hF);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : r;
      k = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      step($urandom_range(0, 14) == 0, $urandom_range(0, 3) != 0, r, d, k);
    end
    idle(1);

    for (int i = 0; i < 5 && (qa.size() > 0 || qb.size() > 0); i++) @(posedge clk);
    #3;
    check("queue_drain", 32'(qa.size() + qb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
